count_uart_reporter: RTL

- Downstream consumer of the 8-bit LED count produced by the one-second LED counter.
- Whenever the count changes, transmits its value over a UART 8N1 line as a 4-byte ASCII frame: two uppercase hex digits, then CR and LF.
- This lets the count be observed remotely from a serial terminal alongside the physical LEDs.
- `count` is driven from the same `clk` domain, so no synchroniser is required.

---
 rtl/count_uart_reporter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/count_uart_reporter.sv
// count_uart_reporter
// Watches the 8-bit LED count and, whenever it changes, transmits the new
// value on a UART 8N1 line as "HH\r\n" (two uppercase hex digits, CR, LF).
// Changes that arrive mid-frame collapse into a single pending value, which
// is sent back-to-back after the current frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle high, waiting for the count to change
// S_START | start bit (low) for DIV cycles
// S_DATA  | eight data bits, LSB first, DIV cycles each
// S_STOP  | stop bit (high) for DIV cycles, then next byte / frame / idle
module count_uart_reporter #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] count,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CYC_LOAD = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_prev;
    logic [7:0]    r_snap;
    logic [7:0]    r_latest;
    logic          r_pending;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;

    state_t        w_nxt_state;
    logic [7:0]    w_nxt_snap;
    logic [7:0]    w_nxt_latest;
    logic          w_nxt_pending;
    logic [CW-1:0] w_nxt_cyc;
    logic [2:0]    w_nxt_bit;
    logic [1:0]    w_nxt_byte;
    logic          w_event;
    logic [7:0]    w_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_event = (count != r_prev);

    // Select the byte of the frame currently being shifted out.
    always_comb begin
        w_byte = 8'h0A;
        case (r_byte)
            2'd0:    w_byte = hex_ascii(r_snap[7:4]);
            2'd1:    w_byte = hex_ascii(r_snap[3:0]);
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // Next-state, counter and snapshot logic plus the line outputs.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_snap    = r_snap;
        w_nxt_latest  = r_latest;
        w_nxt_pending = r_pending;
        w_nxt_cyc     = r_cyc;
        w_nxt_bit     = r_bit;
        w_nxt_byte    = r_byte;
        tx            = 1'b1;
        busy          = 1'b1;

        // Mid-frame changes only keep the newest value; the final stop
        // bit below may consume the change directly instead.
        if (w_event && (r_state != S_IDLE)) begin
            w_nxt_latest  = count;
            w_nxt_pending = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_event) begin
                    w_nxt_snap  = count;
                    w_nxt_state = S_START;
                    w_nxt_cyc   = CYC_LOAD;
                    w_nxt_byte  = 2'd0;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (r_cyc == '0) begin
                    w_nxt_state = S_DATA;
                    w_nxt_cyc   = CYC_LOAD;
                    w_nxt_bit   = 3'd0;
                end else begin
                    w_nxt_cyc = r_cyc - 1'b1;
                end
            end
            S_DATA: begin
                tx = w_byte[r_bit];
                if (r_cyc == '0) begin
                    w_nxt_cyc = CYC_LOAD;
                    if (r_bit == 3'd7) begin
                        w_nxt_state = S_STOP;
                    end else begin
                        w_nxt_bit = r_bit + 3'd1;
                    end
                end else begin
                    w_nxt_cyc = r_cyc - 1'b1;
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (r_cyc == '0) begin
                    w_nxt_cyc = CYC_LOAD;
                    if (r_byte != 2'd3) begin
                        w_nxt_byte  = r_byte + 2'd1;
                        w_nxt_state = S_START;
                    end else if (w_event) begin
                        // A change on the very last stop cycle goes out next.
                        w_nxt_snap    = count;
                        w_nxt_pending = 1'b0;
                        w_nxt_byte    = 2'd0;
                        w_nxt_state   = S_START;
                    end else if (r_pending) begin
                        w_nxt_snap    = r_latest;
                        w_nxt_pending = 1'b0;
                        w_nxt_byte    = 2'd0;
                        w_nxt_state   = S_START;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cyc = r_cyc - 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_prev    <= 8'h00;
            r_snap    <= 8'h00;
            r_latest  <= 8'h00;
            r_pending <= 1'b0;
            r_cyc     <= '0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
        end else begin
            r_state   <= w_nxt_state;
            r_prev    <= count;
            r_snap    <= w_nxt_snap;
            r_latest  <= w_nxt_latest;
            r_pending <= w_nxt_pending;
            r_cyc     <= w_nxt_cyc;
            r_bit     <= w_nxt_bit;
            r_byte    <= w_nxt_byte;
        end
    end

endmodule
